// File: rtl/spi_config_register_if.sv
// SPI pin bundle between the FPGA master and the configuration register slave.
interface spi_config_register_if;
    logic spi_cs_b;
    logic spi_sclk;
    logic spi_sdi;
    logic spi_sdo;

    modport master (output spi_cs_b, output spi_sclk, output spi_sdi, input spi_sdo);
    modport slave  (input spi_cs_b, input spi_sclk, input spi_sdi, output spi_sdo);
endinterface

// File: rtl/spi_config_register.sv
// SPI slave configuration register: oversampled pins shift into a private register,
// and the configuration is committed only when a transfer of exactly WIDTH bits ends.
module spi_config_register #(
    parameter int               WIDTH       = 1280,
    parameter int               CNT_W       = $clog2(WIDTH + 2),
    parameter int               SYNC_STAGES = 2,
    parameter bit               CPOL        = 1'b0,
    parameter bit               CPHA        = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    spi_config_register_if.slave spi,
    output logic [WIDTH-1:0]     cfg_bits,
    output logic                 cfg_load,
    output logic                 len_err,
    inout  wire                  vdd_d,
    inout  wire                  vss_d
);
    typedef enum logic {IDLE, ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES:0]   vld_pipe_q, vld_pipe_d;
    logic                   cs_dly_q, cs_dly_d;
    logic                   sclk_dly_q, sclk_dly_d;
    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [WIDTH-1:0]       cfg_q, cfg_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   sdo_q, sdo_d;
    logic                   cfg_load_q, cfg_load_d;
    logic                   len_err_q, len_err_d;

    logic cs_s, sclk_s, sdi_s;
    logic cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, launch_edge;
    logic unused_supply;

    assign unused_supply = vdd_d ^ vss_d;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

    // Edges count only once the whole sync chain holds post-reset samples, so a
    // cs_b already low at reset release is never mistaken for a fall.
    assign cs_fall     = vld_pipe_q[SYNC_STAGES] &  cs_dly_q & ~cs_s;
    assign cs_rise     = vld_pipe_q[SYNC_STAGES] & ~cs_dly_q &  cs_s;
    assign lead_edge   = (sclk_dly_q == CPOL) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_dly_q != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign launch_edge = CPHA ? lead_edge  : trail_edge;

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi.spi_cs_b};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.spi_sclk};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0],  spi.spi_sdi};
        vld_pipe_d  = {vld_pipe_q[SYNC_STAGES-1:0],  1'b1};
        cs_dly_d    = cs_s;
        sclk_dly_d  = sclk_s;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        sdo_d      = sdo_q;
        cfg_d      = cfg_q;
        cfg_load_d = 1'b0;
        len_err_d  = len_err_q;
        case (state_q)
            IDLE: begin
                sdo_d = 1'b1;
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    shift_d   = cfg_q;
                    bit_cnt_d = '0;
                    sdo_d     = cfg_q[WIDTH-1];
                end
            end
            ACTIVE: begin
                // cs_b edges win over a coincident sclk edge, which is dropped
                if (cs_rise) begin
                    state_d = IDLE;
                    sdo_d   = 1'b1;
                    if (bit_cnt_q == CNT_W'(WIDTH)) begin
                        cfg_d      = shift_q;
                        cfg_load_d = 1'b1;
                        len_err_d  = 1'b0;
                    end else begin
                        len_err_d  = 1'b1;
                    end
                end else if (sample_edge) begin
                    shift_d = {shift_q[WIDTH-2:0], sdi_s};
                    if (bit_cnt_q != CNT_W'(WIDTH + 1))
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else if (launch_edge) begin
                    sdo_d = shift_q[WIDTH-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            sdi_sync_q  <= '0;
            vld_pipe_q  <= '0;
            cs_dly_q    <= 1'b1;
            sclk_dly_q  <= CPOL;
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            sdo_q       <= 1'b1;
            cfg_q       <= RESET_VAL;
            cfg_load_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            vld_pipe_q  <= vld_pipe_d;
            cs_dly_q    <= cs_dly_d;
            sclk_dly_q  <= sclk_dly_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sdo_q       <= sdo_d;
            cfg_q       <= cfg_d;
            cfg_load_q  <= cfg_load_d;
            len_err_q   <= len_err_d;
        end
    end

    assign spi.spi_sdo = sdo_q;
    assign cfg_bits    = cfg_q;
    assign cfg_load    = cfg_load_q;
    assign len_err     = len_err_q;
endmodule

// File: tb/tb_spi_config_register.sv
// Bench: one 1280-bit mode-0 instance plus four 48-bit instances covering all SPI modes,
// driven by an SPI master model and checked against a bit-stream reference model.
module tb_spi_config_register;
    localparam int NI = 5;
    localparam int SS = 2;
    localparam int HP = SS + 2;
    localparam int WM = 1280;
    localparam int WS = 48;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic cs_b [NI];
    logic sclk [NI];
    logic sdi  [NI];
    wire          sdo_w  [NI];
    wire          load_w [NI];
    wire          lerr_w [NI];
    wire [WM-1:0] cfg_w  [NI];
    wire vdd_w, vss_w;
    assign vdd_w = 1'b1;
    assign vss_w = 1'b0;

    bit          cpol_a [NI];
    bit          cpha_a [NI];
    int          w_a    [NI];
    logic [WM-1:0] mdl  [NI];
    bit          mlen   [NI];
    int          load_cnt [NI];
    int          load_cyc [NI];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    spi_config_register_if ifm ();
    assign ifm.spi_cs_b = cs_b[0];
    assign ifm.spi_sclk = sclk[0];
    assign ifm.spi_sdi  = sdi[0];
    assign sdo_w[0]     = ifm.spi_sdo;

    spi_config_register #(.WIDTH(WM), .SYNC_STAGES(SS)) u_dut (
        .clk(clk), .rst_b(rst_b), .spi(ifm), .cfg_bits(cfg_w[0]), .cfg_load(load_w[0]),
        .len_err(lerr_w[0]), .vdd_d(vdd_w), .vss_d(vss_w));

    for (genvar g = 0; g < 4; g++) begin : g_mode
        localparam bit GPOL = (g / 2) == 1;
        localparam bit GPHA = (g % 2) == 1;
        spi_config_register_if ifs ();
        wire [WS-1:0] c;
        assign ifs.spi_cs_b = cs_b[g+1];
        assign ifs.spi_sclk = sclk[g+1];
        assign ifs.spi_sdi  = sdi[g+1];
        assign sdo_w[g+1]   = ifs.spi_sdo;
        assign cfg_w[g+1]   = WM'(c);
        spi_config_register #(.WIDTH(WS), .SYNC_STAGES(SS), .CPOL(GPOL), .CPHA(GPHA)) u_dut (
            .clk(clk), .rst_b(rst_b), .spi(ifs), .cfg_bits(c), .cfg_load(load_w[g+1]),
            .len_err(lerr_w[g+1]), .vdd_d(vdd_w), .vss_d(vss_w));
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        for (int k = 0; k < NI; k++)
            if (load_w[k] === 1'b1) begin
                load_cnt[k]++;
                load_cyc[k] = cyc;
            end

    task automatic chk(input string tag, input logic [WM-1:0] got, input logic [WM-1:0] exp);
        int hb;
        n_chk++;
        if (got === exp) n_pass++;
        else begin
            hb = -1;
            for (int i = 0; i < WM; i++) if (got[i] !== exp[i]) hb = i;
            $display("FAIL %s: got %h expected %h (low 64 bits), highest differing bit %0d",
                     tag, got[63:0], exp[63:0], hb);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit dbit(input int dm, input int i);
        logic [7:0] a5;
        a5 = 8'hA5;
        case (dm)
            0:       return 1'($urandom_range(0, 1));
            1:       return a5[7 - (i % 8)];
            default: return 1'b0;
        endcase
    endfunction

    // The slave behaves as a WIDTH-deep bit FIFO preloaded with the active
    // configuration: readback bit i is element i of {cfg MSB-first, written bits}.
    task automatic xfer(input int k, input int nbits, input int dm, input bit coinc,
                        input bit desel, input string nm);
        bit            rq[$];
        bit            wq[$];
        logic [WM-1:0] nw;
        int            w, l0, rb_err, c0, eff;
        bit            pol, pha, valid;
        w = w_a[k];
        pol = cpol_a[k];
        pha = cpha_a[k];
        for (int i = w - 1; i >= 0; i--) rq.push_back(mdl[k][i]);
        for (int i = 0; i < nbits; i++) begin
            wq.push_back(dbit(dm, i));
            rq.push_back(wq[i]);
        end
        l0 = load_cnt[k];
        rb_err = 0;
        c0 = 0;
        @(negedge clk);
        cs_b[k] = 1'b0;
        if (!pha) sdi[k] = wq[0];
        wait_cyc(HP);
        for (int i = 0; i < nbits; i++) begin
            if (!pha) begin
                if (sdo_w[k] !== rq[i]) rb_err++;
                sclk[k] = ~pol;
                if (coinc && i == nbits - 1) begin cs_b[k] = 1'b1; c0 = cyc; end
                wait_cyc(HP);
                sclk[k] = pol;
                if (i + 1 < nbits) sdi[k] = wq[i+1];
                wait_cyc(HP);
            end else begin
                sclk[k] = ~pol;
                sdi[k] = wq[i];
                wait_cyc(HP);
                if (sdo_w[k] !== rq[i]) rb_err++;
                sclk[k] = pol;
                if (coinc && i == nbits - 1) begin cs_b[k] = 1'b1; c0 = cyc; end
                wait_cyc(HP);
            end
        end
        chk({nm, "_readback_errs"}, WM'(rb_err), '0);
        if (!desel) return;
        if (!coinc) begin
            cs_b[k] = 1'b1;
            c0 = cyc;
        end
        wait_cyc(HP + 2);
        eff = coinc ? nbits - 1 : nbits;
        valid = (eff == w);
        if (valid) begin
            nw = '0;
            for (int j = 0; j < w; j++) nw[w-1-j] = wq[eff-w+j];
            mdl[k] = nw;
        end
        mlen[k] = !valid;
        chk({nm, "_cfg"}, cfg_w[k], mdl[k]);
        chk({nm, "_len_err"}, WM'(lerr_w[k]), WM'(mlen[k]));
        chk({nm, "_loads"}, WM'(load_cnt[k] - l0), WM'(valid));
        if (valid) chk({nm, "_load_lat"}, WM'(load_cyc[k] - c0), WM'(SS + 1));
        chk({nm, "_sdo_idle"}, WM'(sdo_w[k]), WM'(1'b1));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WM-1:0] a5_pat;
        int l0;
        for (int k = 0; k < NI; k++) begin
            cpol_a[k] = (k == 0) ? 1'b0 : ((k - 1) / 2 == 1);
            cpha_a[k] = (k == 0) ? 1'b0 : ((k - 1) % 2 == 1);
            w_a[k]    = (k == 0) ? WM : WS;
            cs_b[k]   = 1'b1;
            sclk[k]   = cpol_a[k];
            sdi[k]    = 1'b0;
            mdl[k]    = '0;
            mlen[k]   = 1'b0;
            load_cnt[k] = 0;
            load_cyc[k] = 0;
        end
        a5_pat = {160{8'hA5}};
        wait_cyc(3);
        rst_b = 1'b1;
        wait_cyc(10);
        for (int k = 0; k < NI; k++) begin
            chk("rst_cfg", cfg_w[k], '0);
            chk("rst_sdo", WM'(sdo_w[k]), WM'(1'b1));
            chk("rst_load", WM'(load_w[k]), '0);
            chk("rst_len_err", WM'(lerr_w[k]), '0);
        end

        fork
            begin
                xfer(0, WM, 1, 1'b0, 1'b1, "a5_wr");
                chk("a5_pattern", cfg_w[0], a5_pat);
                xfer(0, WM - 1, 0, 1'b0, 1'b1, "short");
                xfer(0, WM + 1, 0, 1'b0, 1'b1, "long");
                xfer(0, WM, 2, 1'b0, 1'b1, "zero_wr");
            end
            begin
                for (int k = 1; k < NI; k++) begin
                    xfer(k, WS, 0, 1'b0, 1'b1, "m_wr0");
                    xfer(k, WS, 0, 1'b0, 1'b1, "m_wr1");
                    xfer(k, WS - 1, 0, 1'b0, 1'b1, "m_short");
                    xfer(k, WS + 1, 0, 1'b0, 1'b1, "m_long");
                    xfer(k, WS, 0, 1'b0, 1'b1, "m_wr2");
                end
            end
        join

        // reset mid-transfer, released while cs_b is still low
        xfer(0, WM, 0, 1'b0, 1'b1, "pre_rst");
        xfer(0, 600, 0, 1'b0, 1'b0, "rst_mid");
        rst_b = 1'b0;
        #1;
        chk("rst_mid_cfg", cfg_w[0], '0);
        chk("rst_mid_sdo", WM'(sdo_w[0]), WM'(1'b1));
        chk("rst_mid_len_err", WM'(lerr_w[0]), '0);
        for (int k = 0; k < NI; k++) begin
            mdl[k] = '0;
            mlen[k] = 1'b0;
        end
        wait_cyc(3);
        l0 = load_cnt[0];
        rst_b = 1'b1;
        wait_cyc(10);
        cs_b[0] = 1'b1;
        wait_cyc(HP + 4);
        chk("cs_low_at_release_len_err", WM'(lerr_w[0]), '0);
        chk("cs_low_at_release_loads", WM'(load_cnt[0] - l0), '0);
        for (int k = 0; k < NI; k++) chk("rst_all_cfg", cfg_w[k], mdl[k]);

        xfer(0, WM, 0, 1'b0, 1'b1, "post_rst");
        xfer(0, WM, 0, 1'b1, 1'b1, "coinc");
        sclk[0] = cpol_a[0];
        wait_cyc(HP);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
